// File: rtl/hb_watchdog_pkg.sv
// Shared definitions for the heartbeat watchdog: channel state encoding,
// fault counter width and a small constant helper for counter sizing.
package hb_watchdog_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GRACE = 2'd1,
        ARMED = 2'd2,
        FAULT = 2'd3
    } chan_state_t;

    localparam int unsigned FAULT_CNT_W = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hb_watchdog_chan.sv
// One heartbeat monitoring channel: pin synchronizer, edge detector,
// cycle counter, supervision FSM and saturating fault counter.
module hb_watchdog_chan
    import hb_watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 50_000_000,
    parameter int unsigned MIN_PERIOD_CYCLES = 1_000,
    parameter int unsigned GRACE_CYCLES      = 100_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hb,
    input  logic                   run,
    output logic                   error,
    output logic [FAULT_CNT_W-1:0] fault_cnt,
    output logic [1:0]             state
);

    localparam int unsigned CW = $clog2(max_u(TIMEOUT_CYCLES, GRACE_CYCLES)) + 1;

    // Terminal counter values; zero-valued parameters collapse to 0 rather than wrapping.
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] MIN_LAST     = CW'((MIN_PERIOD_CYCLES > 0) ? MIN_PERIOD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] GRACE_LAST   = CW'((GRACE_CYCLES > 0) ? GRACE_CYCLES - 1 : 0);

    logic          s1, s2, s3;
    logic          hb_edge;
    chan_state_t   cur, nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // Two-flop synchronizer plus a third flop holding the previous synchronized level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= hb;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign hb_edge = s2 ^ s3;

    // Next-state and counter logic; dropping run overrides every other transition.
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        case (cur)
            OFF: begin
                cnt_nxt = '0;
                if (run) nxt = GRACE;
            end
            GRACE: begin
                if (cnt == GRACE_LAST) begin
                    nxt     = ARMED;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ARMED: begin
                if (hb_edge) begin
                    cnt_nxt = '0;
                    if (cnt < MIN_LAST) nxt = FAULT;
                end else if (cnt == TIMEOUT_LAST) begin
                    nxt     = FAULT;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            FAULT: begin
                nxt     = GRACE;
                cnt_nxt = '0;
            end
            default: begin
                nxt     = OFF;
                cnt_nxt = '0;
            end
        endcase
        if (!run) begin
            nxt     = OFF;
            cnt_nxt = '0;
        end
    end

    // State, counter, registered error pulse and saturating fault count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur       <= OFF;
            cnt       <= '0;
            error     <= 1'b0;
            fault_cnt <= '0;
        end else begin
            cur   <= nxt;
            cnt   <= cnt_nxt;
            error <= (nxt == FAULT);
            if (nxt == FAULT && fault_cnt != '1) begin
                fault_cnt <= fault_cnt + FAULT_CNT_W'(1);
            end
        end
    end

    assign state = cur;

endmodule

// File: rtl/hb_watchdog.sv
// Dual-channel heartbeat watchdog: two independent monitors, one per uC.
module hb_watchdog
    import hb_watchdog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 50_000_000,
    parameter int unsigned MIN_PERIOD_CYCLES = 1_000,
    parameter int unsigned GRACE_CYCLES      = 100_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hb_u1,
    input  logic                   hb_u2,
    input  logic                   run_u1,
    input  logic                   run_u2,
    output logic                   errorUC1,
    output logic                   errorUC2,
    output logic [FAULT_CNT_W-1:0] fault_cnt_u1,
    output logic [FAULT_CNT_W-1:0] fault_cnt_u2,
    output logic [1:0]             state_u1,
    output logic [1:0]             state_u2
);

    hb_watchdog_chan #(
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
        .MIN_PERIOD_CYCLES (MIN_PERIOD_CYCLES),
        .GRACE_CYCLES      (GRACE_CYCLES)
    ) u_ch1 (
        .clk       (clk),
        .reset     (reset),
        .hb        (hb_u1),
        .run       (run_u1),
        .error     (errorUC1),
        .fault_cnt (fault_cnt_u1),
        .state     (state_u1)
    );

    hb_watchdog_chan #(
        .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
        .MIN_PERIOD_CYCLES (MIN_PERIOD_CYCLES),
        .GRACE_CYCLES      (GRACE_CYCLES)
    ) u_ch2 (
        .clk       (clk),
        .reset     (reset),
        .hb        (hb_u2),
        .run       (run_u2),
        .error     (errorUC2),
        .fault_cnt (fault_cnt_u2),
        .state     (state_u2)
    );

endmodule

// File: tb/tb_hb_watchdog.sv
// Directed bench for hb_watchdog with TIMEOUT=16, MIN_PERIOD=4, GRACE=8.
module tb_hb_watchdog;

    logic       clk = 1'b0;
    logic       reset, hb_u1, hb_u2, run_u1, run_u2;
    logic       errorUC1, errorUC2;
    logic [3:0] fault_cnt_u1, fault_cnt_u2;
    logic [1:0] state_u1, state_u2;

    int total = 0;
    int bad   = 0;

    hb_watchdog #(
        .TIMEOUT_CYCLES    (16),
        .MIN_PERIOD_CYCLES (4),
        .GRACE_CYCLES      (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hb_u1        (hb_u1),
        .hb_u2        (hb_u2),
        .run_u1       (run_u1),
        .run_u2       (run_u2),
        .errorUC1     (errorUC1),
        .errorUC2     (errorUC2),
        .fault_cnt_u1 (fault_cnt_u1),
        .fault_cnt_u2 (fault_cnt_u2),
        .state_u1     (state_u1),
        .state_u2     (state_u2)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_st1"}, 32'(state_u1), 0);
        chk({tag, "_st2"}, 32'(state_u2), 0);
        chk({tag, "_err1"}, 32'(errorUC1), 0);
        chk({tag, "_err2"}, 32'(errorUC2), 0);
        chk({tag, "_fc1"}, 32'(fault_cnt_u1), 0);
        chk({tag, "_fc2"}, 32'(fault_cnt_u2), 0);
    endtask

    int gaps[5] = '{10, 10, 4, 10, 10};

    initial begin
        reset  = 1'b0;
        hb_u1  = 1'b0;
        hb_u2  = 1'b0;
        run_u1 = 1'b0;
        run_u2 = 1'b0;
        repeat (3) tick;
        chk_all_zero("reset");

        reset = 1'b1;
        tick;
        chk("off_idle", 32'(state_u1), 0);

        // channel 1 boot: GRACE for 8 cycles then ARMED
        run_u1 = 1'b1;
        tick;
        chk("c1_grace_enter", 32'(state_u1), 1);
        repeat (7) tick;
        chk("c1_grace_last", 32'(state_u1), 1);
        tick;
        chk("c1_armed", 32'(state_u1), 2);

        // healthy heartbeat, including a gap of exactly the minimum period
        repeat (5) begin tick; chk("c1_pre_err", 32'(errorUC1), 0); end
        hb_u1 = ~hb_u1;
        foreach (gaps[g]) begin
            repeat (gaps[g]) begin tick; chk("c1_healthy_err", 32'(errorUC1), 0); end
            hb_u1 = ~hb_u1;
        end
        chk("c1_healthy_state", 32'(state_u1), 2);
        chk("c1_healthy_fc", 32'(fault_cnt_u1), 0);

        // edge consumed exactly when counter==15: edge wins, counter restarts
        repeat (16) begin tick; chk("c1_bound_err", 32'(errorUC1), 0); end
        hb_u1 = ~hb_u1;

        // heartbeat stops: pulse 19 cycles after the pin toggle
        repeat (18) begin tick; chk("c1_to_wait_err", 32'(errorUC1), 0); end
        chk("c1_to_wait_st", 32'(state_u1), 2);
        tick;
        chk("c1_to_err", 32'(errorUC1), 1);
        chk("c1_to_state", 32'(state_u1), 3);
        chk("c1_to_fc", 32'(fault_cnt_u1), 1);
        chk("c1_to_c2_err", 32'(errorUC2), 0);
        tick;
        chk("c1_post_err", 32'(errorUC1), 0);
        chk("c1_post_state", 32'(state_u1), 1);

        // run dropped with counter at 15 in ARMED: OFF, no pulse
        repeat (7) tick;
        chk("c1_regrace", 32'(state_u1), 1);
        tick;
        chk("c1_rearmed", 32'(state_u1), 2);
        repeat (15) tick;
        chk("c1_cnt15_state", 32'(state_u1), 2);
        chk("c1_cnt15_err", 32'(errorUC1), 0);
        run_u1 = 1'b0;
        tick;
        chk("c1_drop_err", 32'(errorUC1), 0);
        chk("c1_drop_state", 32'(state_u1), 0);
        chk("c1_drop_fc", 32'(fault_cnt_u1), 1);
        repeat (3) begin tick; chk("c1_off_err", 32'(errorUC1), 0); end

        // channel 2: toggles 2 cycles apart -> too-fast fault
        run_u2 = 1'b1;
        tick;
        chk("c2_grace", 32'(state_u2), 1);
        repeat (7) tick;
        tick;
        chk("c2_armed", 32'(state_u2), 2);
        repeat (5) tick;
        hb_u2 = ~hb_u2;
        repeat (2) begin tick; chk("c2_fast_wait1", 32'(errorUC2), 0); end
        hb_u2 = ~hb_u2;
        repeat (2) begin tick; chk("c2_fast_wait2", 32'(errorUC2), 0); end
        tick;
        chk("c2_fast_err", 32'(errorUC2), 1);
        chk("c2_fast_state", 32'(state_u2), 3);
        chk("c2_fast_fc", 32'(fault_cnt_u2), 1);
        chk("c2_c1_err", 32'(errorUC1), 0);
        chk("c2_c1_state", 32'(state_u1), 0);
        chk("c2_c1_fc", 32'(fault_cnt_u1), 1);

        // 20 more timeout faults, 25 cycles apart: counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            repeat (24) begin tick; chk("c2_sat_quiet", 32'(errorUC2), 0); end
            tick;
            chk("c2_sat_err", 32'(errorUC2), 1);
            chk("c2_sat_fc", 32'(fault_cnt_u2), (i + 2 > 15) ? 15 : i + 2);
        end

        // reset at the edge that would enter FAULT: no pulse, everything cleared
        repeat (24) tick;
        chk("c2_prefault_state", 32'(state_u2), 2);
        reset = 1'b0;
        tick;
        chk_all_zero("rst_fault");
        tick;
        chk_all_zero("rst_hold");
        reset = 1'b1;
        tick;
        chk("rel_c2_state", 32'(state_u2), 1);
        chk("rel_c2_err", 32'(errorUC2), 0);
        chk("rel_c1_state", 32'(state_u1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hb_watchdog.md
HB_WATCHDOG -- requirements
Module: hb_watchdog

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, max cycles allowed between heartbeat edges.
REQ-002 SHALL have parameter MIN_PERIOD_CYCLES, default 1_000, min cycles allowed between heartbeat edges.
REQ-003 SHALL have parameter GRACE_CYCLES, default 100_000_000, boot window after a uC starts running, with no checks.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports hb_u1, hb_u2  input  1 each  asynchronous heartbeat toggle pins from uC1/uC2.
REQ-007 SHALL have ports run_u1, run_u2  input  1 each  1 = uC powered and released, 0 = held off (driven from supervisor reset outputs).
REQ-008 SHALL have ports errorUC1, errorUC2  output  1 each  one-cycle fault pulse to supervisor.
REQ-009 SHALL have ports fault_cnt_u1, fault_cnt_u2  output  4 each  saturating fault counters.
REQ-010 SHALL have ports state_u1, state_u2  output  2 each  channel FSM state for debug.

Function
REQ-011 SHALL pass each hb_uX through a 2-flop synchronizer; heartbeat edge (rise or fall) = sync stage 2 differs from stage 3 register.
REQ-012 SHALL run two independent identical channels; no cross-channel interaction.
REQ-013 SHALL implement per-channel FSM: OFF=0, GRACE=1, ARMED=2, FAULT=3.
REQ-014 OFF: counter held 0, error 0; run_uX=1 -> GRACE next cycle.
REQ-015 GRACE: counter increments each cycle; heartbeat edges ignored; counter==GRACE_CYCLES-1 -> ARMED, counter cleared.
REQ-016 ARMED: counter increments, clears to 0 on each detected edge.
REQ-017 ARMED: edge detected while counter < MIN_PERIOD_CYCLES-1 -> FAULT (too fast).
REQ-018 ARMED: counter==TIMEOUT_CYCLES-1 with no edge in that cycle -> FAULT (timeout); edge in that same cycle wins, counter clears.
REQ-019 FAULT: errorUCx=1 for exactly one cycle; fault_cnt increments saturating at 15; unconditional -> GRACE next cycle, counter cleared.
REQ-020 run_uX=0 in any state -> OFF next cycle, overriding all other transitions; no error pulse generated.
REQ-021 errorUCx SHALL be registered and equal 1 only during the FAULT cycle.
REQ-022 Counter width SHALL be clog2(max(TIMEOUT_CYCLES, GRACE_CYCLES))+1 bits, unsigned; counter never wraps (bounded by REQ-015/018).
REQ-023 Fault-detection latency: timeout fault pulse appears TIMEOUT_CYCLES+1 cycles after the last detected edge; edge detection lags hb pin by 3 cycles.

Reset
REQ-024 reset=0 at a clock edge SHALL force: both FSMs OFF, counters 0, errorUC1/2=0, fault_cnt=0, state outputs 0, synchronizer flops 0.
REQ-025 Reset asserted mid-FAULT SHALL suppress the pending pulse; the first cycle after release evaluates run_uX from OFF.

Structure
REQ-026 Shared package hb_watchdog_pkg SHALL hold state encodings OFF/GRACE/ARMED/FAULT and the fault_cnt width constant 4.
REQ-027 Per-channel logic (sync, edge detect, counter, FSM, fault counter) SHALL be sub-module hb_watchdog_chan, instantiated twice.

Verification (TIMEOUT=16, MIN_PERIOD=4, GRACE=8)
REQ-028 run_u1=1, toggle hb_u1 every 10 cycles after GRACE -> errorUC1 never asserts, state_u1=2.
REQ-029 run_u1=1, hb_u1 stops toggling in ARMED -> one-cycle errorUC1 17 cycles after last detected edge, fault_cnt_u1=1, state back to GRACE.
REQ-030 ARMED, hb_u2 toggled 2 cycles apart -> errorUC2 pulse, fault_cnt_u2=1; channel 1 unaffected.
REQ-031 Edge detected exactly at counter==15 -> no fault, counter=0; 20 forced faults -> fault_cnt saturates at 15.
REQ-032 run_u1 dropped while counter=15 in ARMED, and reset=0 during FAULT -> no errorUC1 pulse; all outputs 0 after reset.
